// File: rtl/reloj_ctrl.sv
// Clock time-keeping/setting controller: 1 Hz prescaler, RUN/SET_HOUR/SET_MIN FSM, counter enables.
// Latency: enables combinational from registered state; an Inc press reaches its enable 1 cycle after sampling.
// Backpressure: none; counters must accept every 1-cycle enable pulse as it is issued.
module reloj_ctrl #(
   parameter int DIV        = 50_000_000,
   parameter int HOLD_TICKS = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       BtnMode,
   input  logic       BtnInc,
   input  logic       SecRCO,
   input  logic       MinRCO,
   output logic       SecEn,
   output logic       MinEn,
   output logic       HourEn,
   output logic [1:0] Mode,
   output logic       Blink,
   output logic       Tick
);

   localparam int CW = $clog2(DIV);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

   typedef enum logic [1:0] {
      S_RUN      = 2'b00,
      S_SET_HOUR = 2'b01,
      S_SET_MIN  = 2'b10
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] presc;
   logic [HW-1:0] hold_cnt;
   logic          mode_d1, mode_d2;
   logic          inc_d1, inc_d2;

   logic          tick;
   logic          mode_edge;
   logic          inc_edge;
   logic          rep_pulse;
   logic          inc_pulse;
   logic          enter_run;

   assign tick      = (presc == CNT_MAX);
   assign mode_edge = mode_d1 & ~mode_d2;
   assign inc_edge  = inc_d1 & ~inc_d2;
   // Once the hold count saturates, every Tick with Inc still down repeats the increment.
   assign rep_pulse = tick & inc_d1 & (hold_cnt == HOLD_MAX);
   // A mode change in the same cycle swallows any increment so no field is bumped mid-switch.
   assign inc_pulse = (inc_edge | rep_pulse) & ~mode_edge;
   // Restarting the prescaler on return to RUN gives a full second before the first tick.
   assign enter_run = (state != S_RUN) && (state_nxt == S_RUN);
   assign Tick      = tick;

   // Prescaler: free-running 0..DIV-1, restarted when the FSM re-enters RUN.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         presc <= '0;
      end else if (enter_run || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + CW'(1);
      end
   end

   // Button history: two-stage shift so a rising level becomes a single-cycle edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         mode_d1 <= 1'b0;
         mode_d2 <= 1'b0;
         inc_d1  <= 1'b0;
         inc_d2  <= 1'b0;
      end else begin
         mode_d1 <= BtnMode;
         mode_d2 <= mode_d1;
         inc_d1  <= BtnInc;
         inc_d2  <= inc_d1;
      end
   end

   // Hold counter: counts Ticks while Inc is held in a set mode, saturating to arm auto-repeat.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         hold_cnt <= '0;
      end else if (!inc_d1 || (state == S_RUN) || mode_edge) begin
         hold_cnt <= '0;
      end else if (tick && (hold_cnt != HOLD_MAX)) begin
         hold_cnt <= hold_cnt + HW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= S_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and outputs: mode advances only on a Mode edge; enables depend on the mode.
   always_comb begin
      state_nxt = state;
      SecEn     = 1'b0;
      MinEn     = 1'b0;
      HourEn    = 1'b0;
      Mode      = 2'b00;
      Blink     = 1'b0;
      case (state)
         S_RUN: begin
            if (mode_edge) state_nxt = S_SET_HOUR;
            SecEn  = tick;
            MinEn  = tick & SecRCO;
            HourEn = tick & SecRCO & MinRCO;
            Mode   = 2'b00;
         end
         S_SET_HOUR: begin
            if (mode_edge) state_nxt = S_SET_MIN;
            HourEn = inc_pulse;
            Mode   = 2'b01;
            Blink  = (presc < CNT_HALF);
         end
         S_SET_MIN: begin
            if (mode_edge) state_nxt = S_RUN;
            // Minutes roll 59->00 on their own here; no carry is passed to hours.
            MinEn = inc_pulse;
            Mode  = 2'b10;
            Blink = (presc < CNT_HALF);
         end
         default: begin
            state_nxt = S_RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_reloj_ctrl.sv
// Bench for reloj_ctrl with DIV=4, HOLD_TICKS=2: vector table plus hand sequences.
// Latency: outputs sampled 1 time unit after each falling edge, inputs driven on falling edges.
// Backpressure: not applicable.
module tb_reloj_ctrl;

   logic       Clk;
   logic       Reset;
   logic       BtnMode, BtnInc, SecRCO, MinRCO;
   logic       SecEn, MinEn, HourEn, Blink, Tick;
   logic [1:0] Mode;
   logic [6:0] obs;

   int total  = 0;
   int passed = 0;

   reloj_ctrl #(.DIV(4), .HOLD_TICKS(2)) dut (
      .Clk(Clk), .Reset(Reset), .BtnMode(BtnMode), .BtnInc(BtnInc),
      .SecRCO(SecRCO), .MinRCO(MinRCO), .SecEn(SecEn), .MinEn(MinEn),
      .HourEn(HourEn), .Mode(Mode), .Blink(Blink), .Tick(Tick)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Observed output vector: {SecEn, MinEn, HourEn, Mode[1:0], Blink, Tick}
   assign obs = {SecEn, MinEn, HourEn, Mode, Blink, Tick};

   typedef struct {
      logic       m, i, s, n;
      logic [6:0] exp;
   } vec_t;

   typedef struct {
      int         row;
      logic [6:0] v;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb[$];

   task automatic add(input logic m, input logic i, input logic s, input logic n, input logic [6:0] e);
      vec_t r;
      r.m = m; r.i = i; r.s = s; r.n = n; r.exp = e;
      tbl.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      else passed++;
   endtask

   task automatic press_mode();
      BtnMode = 1'b1;
      @(negedge Clk);
      BtnMode = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   ticks, hour, tick_hour, other, extra, en6;
      logic [3:0] tpat;
      sb_t  e;

      Reset = 1'b0; BtnMode = 1'b0; BtnInc = 1'b0; SecRCO = 1'b0; MinRCO = 1'b0;

      //        m  i  s  n   sec min hr mode blink tick
      add(0, 0, 0, 0, 7'b000_00_0_0); // r0  presc 0 after release
      add(0, 0, 1, 1, 7'b000_00_0_0); // r1  RCOs high, no tick
      add(0, 0, 0, 0, 7'b000_00_0_0); // r2
      add(0, 0, 1, 1, 7'b111_00_0_1); // r3  full carry chain on tick
      add(0, 0, 0, 0, 7'b000_00_0_0); // r4
      add(0, 0, 0, 1, 7'b000_00_0_0); // r5
      add(0, 0, 0, 0, 7'b000_00_0_0); // r6
      add(0, 0, 1, 0, 7'b110_00_0_1); // r7  sec+min only
      add(0, 0, 0, 0, 7'b000_00_0_0); // r8
      add(0, 1, 0, 0, 7'b000_00_0_0); // r9  Inc in RUN
      add(0, 0, 0, 0, 7'b000_00_0_0); // r10 Inc edge ignored
      add(0, 0, 0, 1, 7'b100_00_0_1); // r11 MinRCO alone gives no carry
      add(1, 0, 0, 0, 7'b000_00_0_0); // r12 Mode press
      add(0, 0, 0, 0, 7'b000_00_0_0); // r13 edge cycle, still RUN
      add(0, 0, 0, 0, 7'b000_01_0_0); // r14 SET_HOUR, presc 2
      add(0, 0, 1, 1, 7'b000_01_0_1); // r15 tick, no enables
      add(0, 0, 0, 0, 7'b000_01_1_0); // r16 blink on
      add(1, 0, 0, 0, 7'b000_01_1_0); // r17 Mode press
      add(0, 0, 0, 0, 7'b000_01_0_0); // r18 edge cycle
      add(0, 0, 0, 0, 7'b000_10_0_1); // r19 SET_MIN
      add(0, 1, 0, 1, 7'b000_10_1_0); // r20 Inc high one cycle
      add(0, 0, 0, 1, 7'b010_10_1_0); // r21 single MinEn, no HourEn
      add(0, 0, 0, 0, 7'b000_10_0_0); // r22
      add(0, 0, 1, 1, 7'b000_10_0_1); // r23 tick, nothing enabled
      add(1, 0, 0, 0, 7'b000_10_1_0); // r24 Mode press
      add(0, 0, 0, 0, 7'b000_10_1_0); // r25 edge cycle
      add(0, 0, 0, 0, 7'b000_00_0_0); // r26 RUN, presc restarted
      add(0, 0, 1, 1, 7'b000_00_0_0); // r27 no early tick
      add(0, 0, 0, 0, 7'b000_00_0_0); // r28
      add(0, 0, 1, 0, 7'b110_00_0_1); // r29 first tick 4th cycle

      repeat (3) @(negedge Clk);
      #1 chk("reset_state", obs, 7'b0);
      @(negedge Clk);
      Reset = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         BtnMode = tbl[r].m; BtnInc = tbl[r].i; SecRCO = tbl[r].s; MinRCO = tbl[r].n;
         e.row = r; e.v = tbl[r].exp;
         sb.push_back(e);
         #1;
         e = sb.pop_front();
         chk($sformatf("vec_r%0d", e.row), obs, e.v);
         @(negedge Clk);
      end
      SecRCO = 1'b0; MinRCO = 1'b0;

      // Held Inc in SET_HOUR: one edge pulse, then repeats on Ticks 3..6.
      press_mode();
      #1 chk("enter_set_hour", Mode, 2'b01);
      @(negedge Clk);
      BtnInc = 1'b1;
      ticks = 0; hour = 0; tick_hour = 0; other = 0;
      for (int c = 0; c < 40 && ticks < 6; c++) begin
         @(negedge Clk); #1;
         if (Tick) ticks++;
         if (HourEn) hour++;
         if (HourEn && Tick) tick_hour++;
         if (SecEn || MinEn) other++;
      end
      BtnInc = 1'b0;
      chk("hold_ticks_seen", ticks, 6);
      chk("hold_hour_pulses", hour, 5);
      chk("hold_repeat_on_tick", tick_hour, 4);
      chk("hold_no_sec_min", other, 0);
      extra = 0;
      repeat (8) begin
         @(negedge Clk); #1;
         if (HourEn || MinEn || SecEn) extra++;
      end
      chk("release_no_pulse", extra, 0);

      // Mode and Inc rise together in SET_HOUR: mode wins, no enable.
      @(negedge Clk);
      BtnMode = 1'b1; BtnInc = 1'b1;
      @(negedge Clk); #1;
      en6 = (HourEn || MinEn) ? 1 : 0;
      BtnMode = 1'b0; BtnInc = 1'b0;
      repeat (3) begin
         @(negedge Clk); #1;
         if (HourEn || MinEn) en6++;
      end
      chk("simul_no_enable", en6, 0);
      chk("simul_mode", Mode, 2'b10);

      // Reset mid-operation with Inc held in SET_MIN.
      @(negedge Clk);
      BtnInc = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      #1 chk("reset_mid_outputs", obs, 7'b0);
      @(negedge Clk);
      BtnInc = 1'b0;
      Reset = 1'b1;
      tpat = 4'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         tpat[k] = Tick;
         if (k == 0) chk("reset_mid_mode", Mode, 2'b00);
         @(negedge Clk);
      end
      chk("reset_first_tick", tpat, 4'b1000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
